// File: rtl/aes_inv_round_seq.sv
// Iterative AES inverse-cipher round sequencer: one inverse round per clock, with
// InvSubBytes and round keys supplied combinationally by external blocks.

module aes_inv_round_seq #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic [127:0] isb_in,
    input  logic [127:0] isb_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } fsm_e;

    fsm_e         fsm_r;
    logic [127:0] state_r;
    logic [3:0]   rnd_r;
    logic [3:0]   key_idx_r;
    logic         idle_r;
    logic         out_valid_r;
    logic [127:0] out_data_r;
    logic [127:0] mix_in_s;
    logic [127:0] mix_out_s;
    logic [7:0]   mix_bytes_s [4][4];

    // Row r rotates right by r columns: s'[r][c] = s[r][(c-r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    assign isb_in    = inv_shift_rows(state_r);
    assign mix_in_s  = isb_out ^ round_key;
    assign in_ready  = idle_r & ~rst;
    assign key_idx   = key_idx_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

    // Unpack the column-major word into the row/column byte grid of the mixer.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                mix_bytes_s[r][c] = mix_in_s[127 - 8*(4*c + r) -: 8];
            end
        end
    end

    inv_mix_column u_imc (
        .ip_data (mix_bytes_s),
        .op_data (mix_out_s)
    );

    // Round sequencer; key_idx is registered one step ahead so it matches the state it serves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r       <= ST_IDLE;
            state_r     <= 128'h0;
            rnd_r       <= 4'd0;
            key_idx_r   <= 4'(NR);
            idle_r      <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= 128'h0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_r   <= in_data ^ round_key;
                        rnd_r     <= 4'(NR - 1);
                        key_idx_r <= 4'(NR - 1);
                        idle_r    <= 1'b0;
                        fsm_r     <= ST_ROUND;
                    end else begin
                        key_idx_r <= 4'(NR);
                    end
                end
                ST_ROUND: begin
                    state_r <= mix_out_s;
                    if (rnd_r == 4'd1) begin
                        key_idx_r <= 4'd0;
                        fsm_r     <= ST_FINAL;
                    end else begin
                        rnd_r     <= rnd_r - 4'd1;
                        key_idx_r <= rnd_r - 4'd1;
                    end
                end
                ST_FINAL: begin
                    out_data_r  <= isb_out ^ round_key;
                    out_valid_r <= 1'b1;
                    key_idx_r   <= 4'(NR);
                    fsm_r       <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        idle_r      <= 1'b1;
                        fsm_r       <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    idle_r      <= 1'b1;
                    key_idx_r   <= 4'(NR);
                    fsm_r       <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

module inv_mix_column (
    input  logic [7:0]   ip_data [4][4],
    output logic [127:0] op_data
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    // Each column is multiplied by the circulant {0e,0b,0d,09}; output is column-major.
    always_comb begin
        op_data = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                op_data[127 - 8*(4*c + r) -: 8] =
                    gmul(ip_data[2'(r)][2'(c)],     4'he) ^
                    gmul(ip_data[2'(r + 1)][2'(c)], 4'hb) ^
                    gmul(ip_data[2'(r + 2)][2'(c)], 4'hd) ^
                    gmul(ip_data[2'(r + 3)][2'(c)], 4'h9);
            end
        end
    end
endmodule

// File: tb/tb_aes_inv_round_seq.sv
// Bench for aes_inv_round_seq: FIPS-197 vectors, random blocks encrypted by a
// behavioural AES model, back-pressure, mid-operation reset and an NR=14 instance.

module tb_aes_inv_round_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid_a, in_valid_b, in_ready_a, in_ready_b;
    logic         out_valid_a, out_valid_b, out_ready;
    logic [127:0] in_data;
    logic [127:0] round_key_a, round_key_b, isb_in_a, isb_in_b, isb_out_a, isb_out_b;
    logic [127:0] out_data_a, out_data_b;
    logic [3:0]   key_idx_a, key_idx_b;
    logic [7:0]   sbox [256];
    logic [7:0]   inv_sbox [256];
    logic [127:0] rk_model [15];
    logic [127:0] rk_a [16];
    logic [127:0] rk_b [16];
    int n_vec = 0, n_miss = 0, cyc = 0, last_acc = 0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_inv_round_seq #(.NR(10)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
        .key_idx(key_idx_a), .round_key(round_key_a), .isb_in(isb_in_a), .isb_out(isb_out_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
    );

    aes_inv_round_seq #(.NR(14)) u_dut14 (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
        .key_idx(key_idx_b), .round_key(round_key_b), .isb_in(isb_in_b), .isb_out(isb_out_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
    );

    assign round_key_a = rk_a[key_idx_a];
    assign round_key_b = rk_b[key_idx_b];

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            isb_out_a[127 - 8*k -: 8] = inv_sbox[isb_in_a[127 - 8*k -: 8]];
            isb_out_b[127 - 8*k -: 8] = inv_sbox[isb_in_b[127 - 8*k -: 8]];
        end
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    // S-box from the GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[x]    = b;
            inv_sbox[b] = 8'(x);
        end
    endtask

    task automatic expand_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4*(nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = gm(rc, 8'h02);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int j = 0; j <= nr; j++) rk_model[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    // Forward cipher, used to produce ciphertexts for random plaintexts.
    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input int nr);
        logic [127:0] s, t;
        logic [7:0]   a [4];
        s = pt ^ rk_model[0];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int k = 0; k < 16; k++) s[127 - 8*k -: 8] = sbox[s[127 - 8*k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            if (rd < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = t[127 - 8*(4*c + r) -: 8];
                    for (int r = 0; r < 4; r++)
                        t[127 - 8*(4*c + r) -: 8] = gm(a[r], 8'h02) ^ gm(a[(r + 1) % 4], 8'h03)
                                                    ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
                end
            end
            s = t ^ rk_model[rd];
        end
        return s;
    endfunction

    task automatic load_keys(input bit sel, input int nr);
        for (int j = 0; j <= nr; j++) begin
            if (sel) rk_b[j] = rk_model[j];
            else     rk_a[j] = rk_model[j];
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input bit sel, input logic [127:0] ct);
        int n;
        n = 0;
        while (!(sel ? in_ready_b : in_ready_a) && n < 50) begin
            tick();
            n++;
        end
        chk("ready_wait", 128'(n < 50), 128'd1);
        in_data = ct;
        if (sel) in_valid_b = 1'b1;
        else     in_valid_a = 1'b1;
        tick();
        last_acc   = cyc;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic finish_block(input bit sel, input logic [127:0] exp, input int nr,
                                input bit chk_keys, input string tag);
        int t;
        t = 0;
        while (!(sel ? out_valid_b : out_valid_a) && t < 40) begin
            if (chk_keys && t < nr) chk("key_idx_step", 128'(key_idx_a), 128'(nr - 1 - t));
            tick();
            t++;
        end
        chk({tag, "_latency"}, 128'(t + 1), 128'(nr + 1));
        chk(tag, sel ? out_data_b : out_data_a, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] pt, ct, key;
        int n;
        int acc [3];
        rst = 1'b1; in_valid_a = 1'b0; in_valid_b = 1'b0; out_ready = 1'b1; in_data = 128'h0;
        for (int i = 0; i < 16; i++) begin
            rk_a[i] = 128'h0;
            rk_b[i] = 128'h0;
        end
        build_sbox();
        tick();
        tick();
        chk("rst_in_ready", 128'(in_ready_a), 128'd0);
        chk("rst_out_valid", 128'(out_valid_a), 128'd0);
        chk("rst_out_data", out_data_a, 128'h0);
        chk("rst_key_idx", 128'(key_idx_a), 128'd10);
        chk("rst_key_idx14", 128'(key_idx_b), 128'd14);
        chk("rst_isb_in", isb_in_a, 128'h0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 128'(in_ready_a), 128'd1);

        expand_key({KEY_B, 128'h0}, 4);
        load_keys(1'b0, 10);
        start_block(1'b0, CT_B);
        finish_block(1'b0, PT_B, 10, 1'b0, "appb");
        tick();
        chk("appb_consumed", 128'(out_valid_a), 128'd0);

        expand_key({KEY_C, 128'h0}, 4);
        load_keys(1'b0, 10);
        chk("appc1_idle_key_idx", 128'(key_idx_a), 128'd10);
        start_block(1'b0, CT_C1);
        finish_block(1'b0, PT_C, 10, 1'b1, "appc1");

        // Back-pressure with the next ciphertext already waiting on in_valid.
        tick();
        expand_key({KEY_B, 128'h0}, 4);
        load_keys(1'b0, 10);
        start_block(1'b0, CT_B);
        in_valid_a = 1'b1;
        in_data    = CT_C1;
        out_ready  = 1'b0;
        finish_block(1'b0, PT_B, 10, 1'b0, "bp_first");
        expand_key({KEY_C, 128'h0}, 4);
        load_keys(1'b0, 10);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 128'(out_valid_a), 128'd1);
            chk("bp_out_data", out_data_a, PT_B);
            chk("bp_in_ready", 128'(in_ready_a), 128'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_idle_ready", 128'(in_ready_a), 128'd1);
        chk("bp_idle_out_valid", 128'(out_valid_a), 128'd0);
        chk("bp_not_yet_accepted", 128'(key_idx_a), 128'd10);
        tick();
        chk("bp_second_accepted", 128'(key_idx_a), 128'd9);
        in_valid_a = 1'b0;
        in_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
        finish_block(1'b0, PT_C, 10, 1'b0, "bp_second");

        // Asynchronous reset while key_idx is 5.
        tick();
        expand_key({KEY_B, 128'h0}, 4);
        load_keys(1'b0, 10);
        start_block(1'b0, CT_B);
        n = 0;
        while (key_idx_a != 4'd5 && n < 20) begin
            tick();
            n++;
        end
        chk("midrst_reach_k5", 128'(key_idx_a), 128'd5);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 128'(in_ready_a), 128'd0);
        chk("midrst_out_valid", 128'(out_valid_a), 128'd0);
        chk("midrst_out_data", out_data_a, 128'h0);
        chk("midrst_key_idx", 128'(key_idx_a), 128'd10);
        chk("midrst_isb_in", isb_in_a, 128'h0);
        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid_a) n++;
            tick();
        end
        chk("midrst_no_out_valid", 128'(n), 128'd0);
        start_block(1'b0, CT_B);
        finish_block(1'b0, PT_B, 10, 1'b0, "appb_after_rst");

        // Back-to-back random blocks with out_ready held high.
        for (int i = 0; i < 3; i++) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand_key({key, 128'h0}, 4);
            load_keys(1'b0, 10);
            ct = aes_enc(pt, 10);
            start_block(1'b0, ct);
            acc[i] = last_acc;
            finish_block(1'b0, pt, 10, 1'b0, "rand");
        end
        chk("b2b_spacing_1", 128'(acc[1] - acc[0]), 128'd12);
        chk("b2b_spacing_2", 128'(acc[2] - acc[1]), 128'd12);

        expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        load_keys(1'b1, 14);
        start_block(1'b1, CT_C3);
        finish_block(1'b1, PT_C, 14, 1'b0, "nr14");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
